// File: rtl/tff_toggle_meter.sv
// Counts level changes of the upstream T-FF output over a programmable window
// and hands the saturating count plus overflow flag out through valid/ready.
module tff_toggle_meter #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_out,
  output logic             ovf,
  output logic             cnt_valid,
  input  logic             cnt_ready
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    HOLD
  } state_t;

  state_t             state_reg;
  logic               din_d_reg;
  logic [WIN_W-1:0]   win_reg;
  logic [CNT_W-1:0]   run_reg;
  logic               ovf_run_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               ovf_reg;
  logic               valid_reg;
  logic               busy_reg;

  logic               toggle;
  logic [CNT_W-1:0]   run_next;
  logic               ovf_run_next;

  // Running count for this edge, saturating; overflow flags a lost increment.
  always_comb begin
    toggle       = din ^ din_d_reg;
    run_next     = run_reg;
    ovf_run_next = ovf_run_reg;
    if (toggle) begin
      if (&run_reg) begin
        ovf_run_next = 1'b1;
      end else begin
        run_next = run_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      din_d_reg   <= 1'b0;
      win_reg     <= '0;
      run_reg     <= '0;
      ovf_run_reg <= 1'b0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      din_d_reg <= din;
      case (state_reg)
        IDLE: begin
          if (start && (win_len != '0)) begin
            win_reg     <= win_len;
            run_reg     <= '0;
            ovf_run_reg <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= MEASURE;
          end
        end
        MEASURE: begin
          run_reg     <= run_next;
          ovf_run_reg <= ovf_run_next;
          win_reg     <= win_reg - WIN_W'(1);
          // Last window edge: publish the count including this edge's change.
          if (win_reg == WIN_W'(1)) begin
            cnt_reg   <= run_next;
            ovf_reg   <= ovf_run_next;
            valid_reg <= 1'b1;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_ready) begin
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign cnt_out   = cnt_reg;
  assign ovf       = ovf_reg;
  assign cnt_valid = valid_reg;

endmodule

// File: doc/tff_toggle_meter.md
# tff_toggle_meter

Measurement stage that sits directly downstream of the cascaded T flip-flop block. It consumes that block's `q` output as `din` and counts every level change of `din` over a programmable window of clock cycles. It then presents the saturating count and an overflow flag through a valid/ready handshake to the control/readout logic. It lets the team check toggle rates of the T-FF chain in-system.

## Interface
Parameters:
- `WIN_W`, default 8: width of the window-length input.
- `CNT_W`, default 8: width of the toggle count.

Ports:
- `clk`, input, 1: single clock, all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `din`, input, 1: monitored signal, the `q` of the upstream T-FF stage, synchronous to `clk`.
- `start`, input, 1: start request, sampled only in IDLE.
- `win_len`, input, WIN_W: window length N in cycles, captured with `start`.
- `busy`, output, 1: high in MEASURE and HOLD.
- `cnt_out`, output, CNT_W: toggle count of the last completed window.
- `ovf`, output, 1: the count saturated during the last window.
- `cnt_valid`, output, 1: result available.
- `cnt_ready`, input, 1: consumer accepts the result.

## Operation
- `din_d` is a register loaded with `din` at every clock edge in all states; its reset value is 0.
- `edge` is combinational: `din XOR din_d`.
- State machine has three states: IDLE, MEASURE, HOLD. The reset state is IDLE.
- **IDLE:**
  - `start`=1 and `win_len`≠0: load window counter with `win_len`, clear the running count and `ovf_run`, go to MEASURE.
  - `start`=1 and `win_len`=0: ignored, stay in IDLE.
- **MEASURE:**
  - At every edge, if `edge`=1: running count += 1, saturating at 2^CNT_W−1.
  - If an increment is attempted while the count is already at max, `ovf_run` is set.
  - Window counter decrements by 1 each edge.
  - At the edge where the window counter equals 1:
    - `cnt_out` <= final count, including that edge's increment.
    - `ovf` <= final `ovf_run`.
    - `cnt_valid` <= 1.
    - Go to HOLD.
- **HOLD:**
  - `cnt_out`, `ovf` and `cnt_valid`=1 are held stable.
  - At an edge with `cnt_ready`=1: `cnt_valid` <= 0 and go to IDLE.
  - `cnt_out` and `ovf` keep their value until the next window completes.
- `start` is ignored in MEASURE and HOLD; no queuing.
- `cnt_ready` is ignored while `cnt_valid`=0.
- Reset values: `cnt_out`=0, `ovf`=0, `cnt_valid`=0, `busy`=0, all internal counters 0.

## Timing
- `start` sampled at edge T starts a window covering `edge` evaluations at edges T+1 … T+N.
- `cnt_valid` rises after edge T+N, so the result latency from the `start` edge is N cycles.
- `busy` rises after edge T and falls after the edge where `cnt_valid`=1 and `cnt_ready`=1 are both sampled.
- Minimum spacing between accepted starts is N+2 cycles: window, at least one HOLD cycle, one IDLE cycle.
- A `start` presented on the handshake edge is ignored, because the state is still HOLD.
- `din` changing at edge T (the `start` edge) is not counted.
- `din` changing at edge T+N is counted.
- `win_len`=2^WIN_W−1 is the maximum window; the window counter never wraps.
- Saturation and window end on the same edge: `cnt_out`=max and `ovf`=1.
- `rst` asserted mid-MEASURE or mid-HOLD:
  - All outputs are forced to their reset values immediately, with no clock needed.
  - After release, the block is in IDLE and any partial count is discarded.

## Test plan
- Toggle rate check:
  - Stimulus: `din` toggles every cycle, `win_len`=8, `start` pulse, `cnt_ready`=1.
  - Response: `cnt_valid` high exactly 8 cycles after the start edge, for one cycle; `cnt_out`=8, `ovf`=0.
- Saturation:
  - Stimulus: CNT_W=4, `din` toggles every cycle, `win_len`=20.
  - Response: `cnt_out`=15, `ovf`=1.
  - Follow with `din` constant and `win_len`=5: `cnt_out`=0, `ovf`=0.
- Backpressure:
  - Stimulus: `din` toggles every 2nd cycle, `win_len`=10, `cnt_ready`=0 for 6 cycles after valid, then 1.
  - Response: `cnt_out`=5 held stable with `cnt_valid`=1 through the stall; valid clears the cycle after `cnt_ready`=1.
  - A `start` during the stall is ignored.
- Zero window and window boundaries:
  - `win_len`=0 with `start`: `busy` stays 0.
  - Single `din` change aligned to edge T: not counted, `cnt_out`=0 for `win_len`=3.
  - Single `din` change aligned to edge T+3: `cnt_out`=1.
- Reset mid-operation:
  - Stimulus: assert `rst` at cycle 4 of a 16-cycle window.
  - Response: `busy`, `cnt_valid`, `cnt_out`, `ovf` go to 0 asynchronously.
  - A new `start` after release with `win_len`=4 measures a fresh count.
- Chained with the upstream T-FF pair:
  - Stimulus: upstream `data`=1 constant, `win_len`=16.
  - Response: `cnt_out`=8.
